// File: rtl/pulse_timing_monitor_if.sv
// Pulse-line monitor bundle: the monitored line plus the measurement results.
// The master side drives the line and observes results; the slave side is the monitor.
interface pulse_timing_monitor_if #(
  parameter int CNT_W = 26
);
  logic             sig_in;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] period_cycles;
  logic             meas_valid;
  logic             timeout;

  modport master (
    output sig_in,
    input  high_cycles,
    input  period_cycles,
    input  meas_valid,
    input  timeout
  );

  modport slave (
    input  sig_in,
    output high_cycles,
    output period_cycles,
    output meas_valid,
    output timeout
  );
endinterface

// File: rtl/pulse_timing_monitor.sv
// Measures high time and rise-to-rise period of an asynchronous pulse line in
// sys_clk cycles, strobing each complete measurement and flagging a stalled line.
module pulse_timing_monitor #(
  parameter int CNT_W   = 26,
  parameter int TIMEOUT = 4096
) (
  input logic                  sys_clk,
  input logic                  sys_rst,
  pulse_timing_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic             sig_p0, sig_p1, sig_p2;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             to_q, to_d;

  // Edges are taken from the last two synchronizer stages so they strictly alternate.
  assign rise = sig_p1 & ~sig_p2;
  assign fall = ~sig_p1 & sig_p2;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sig_p0   <= 1'b0;
      sig_p1   <= 1'b0;
      sig_p2   <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_lat_q <= '0;
      high_q   <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      sig_p0   <= mon.sig_in;
      sig_p1   <= sig_p0;
      sig_p2   <= sig_p1;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_lat_q <= hi_lat_d;
      high_q   <= high_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_lat_d = hi_lat_q;
    high_d   = high_q;
    period_d = period_q;
    vld_d    = 1'b0;
    to_d     = to_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      HIGH: begin
        cnt_d = cnt_q + CNT_ONE;
        if (fall) begin
          hi_lat_d = cnt_q;
          state_d  = LOW;
        end else if (cnt_q == TIMEOUT_CNT) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end
      end
      LOW: begin
        cnt_d = cnt_q + CNT_ONE;
        if (rise) begin
          high_d   = hi_lat_q;
          period_d = cnt_q;
          vld_d    = 1'b1;
          to_d     = 1'b0;
          cnt_d    = CNT_ONE;
          state_d  = HIGH;
        end else if (cnt_q == TIMEOUT_CNT) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mon.high_cycles   = high_q;
  assign mon.period_cycles = period_q;
  assign mon.meas_valid    = vld_q;
  assign mon.timeout       = to_q;

endmodule
